// File: rtl/key_packer.sv
// key_packer: collects a byte stream into a left-aligned key and hands it to the hash stage.
module key_packer #(
   parameter int MAX_BYTES = 52
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             i_byte,
   input  logic                   i_byte_valid,
   input  logic                   i_byte_last,
   output logic                   o_byte_ready,
   output logic [8*MAX_BYTES-1:0] o_data,
   output logic [31:0]            o_length,
   output logic                   o_start,
   input  logic                   i_stall_pipe,
   output logic                   o_overflow
);
   localparam int CW = $clog2(MAX_BYTES + 1);
   typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
   state_t state, state_next;
   logic [CW-1:0] count;
   logic dropped, accept, full;
   assign o_byte_ready = state != EMIT;
   assign o_start      = state == EMIT;
   assign o_length     = o_start ? 32'(count) : 32'd0;
   assign accept       = i_byte_valid && o_byte_ready;
   assign full         = count == CW'(MAX_BYTES);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_next;
   always_comb begin
      state_next = state;
      state_next = (state == EMIT) ? (i_stall_pipe ? EMIT : IDLE)
                 : accept ? (i_byte_last ? EMIT : ACCUM) : state;
   end
   // dropped remembers an overflow already reported so the pulse fires once per key
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_data     <= '0;
         count      <= '0;
         dropped    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= 1'b0;
         if (state == EMIT) begin
            if (!i_stall_pipe) begin
               o_data  <= '0;
               count   <= '0;
               dropped <= 1'b0;
            end
         end else if (accept) begin
            if (full) begin
               o_overflow <= !dropped;
               dropped    <= 1'b1;
            end else begin
               o_data[8*(MAX_BYTES-1-int'(count)) +: 8] <= i_byte;
               count <= count + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_key_packer.sv
// tb_key_packer: scoreboard bench for key_packer; expected keys queued at send, checked on o_start.
module tb_key_packer;
   localparam int MB = 52;
   localparam int W  = 8 * MB;
   typedef logic [7:0] bq_t[$];
   typedef struct {logic [W-1:0] d; logic [31:0] len;} exp_t;

   logic clk = 0, rst = 1;
   logic [7:0] i_byte = 0;
   logic i_byte_valid = 0, i_byte_last = 0, i_stall_pipe = 0;
   logic o_byte_ready, o_start, o_overflow;
   logic [W-1:0] o_data;
   logic [31:0] o_length;

   key_packer #(.MAX_BYTES(MB)) dut (
      .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
      .i_byte_last(i_byte_last), .o_byte_ready(o_byte_ready), .o_data(o_data),
      .o_length(o_length), .o_start(o_start), .i_stall_pipe(i_stall_pipe),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   int total = 0, pass = 0, sent = 0, cyc = 0, ovf_cnt = 0, ovf_at = -1;
   exp_t sb[$];
   exp_t cur;
   int starts[$];
   logic prev_start = 0;

   always @(posedge clk) cyc++;

   // scoreboard: pop on rising o_start, then compare every cycle the key is presented
   always @(negedge clk) begin
      if (rst) prev_start = 0;
      else begin
         if (o_overflow) begin ovf_cnt++; ovf_at = sent; end
         if (o_start) begin
            if (!prev_start) begin
               starts.push_back(cyc);
               total++;
               if (sb.size() == 0) $display("FAIL sb_unexpected_start got start=1 want no key pending");
               else begin pass++; cur = sb.pop_front(); end
            end
            total++;
            if (o_data !== cur.d) $display("FAIL sb_data got %h want %h", o_data, cur.d);
            else pass++;
            total++;
            if (o_length !== cur.len) $display("FAIL sb_length got %0d want %0d", o_length, cur.len);
            else pass++;
         end
         prev_start = o_start;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic put(input logic [7:0] b, input logic last);
      int w = 0;
      i_byte = b; i_byte_valid = 1'b1; i_byte_last = last;
      while (!o_byte_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (w == 50) begin total++; $display("FAIL put_ready got %b want 1", o_byte_ready); end
      @(posedge clk); #1;
      sent++;
   endtask

   task automatic quiet();
      i_byte_valid = 1'b0; i_byte_last = 1'b0; i_byte = 8'h00;
   endtask

   task automatic send_key(input bq_t q);
      exp_t e;
      int n = q.size();
      e.d = '0;
      for (int i = 0; i < n && i < MB; i++) e.d[W-1-8*i -: 8] = q[i];
      e.len = (n > MB) ? MB : n;
      sb.push_back(e);
      for (int i = 0; i < n; i++) put(q[i], i == n - 1);
      quiet();
   endtask

   task automatic wait_done();
      int w = 0;
      while (o_start && w < 100) begin @(posedge clk); #1; w++; end
      total++;
      if (o_start !== 1'b0) $display("FAIL wait_done got start=%b want 0", o_start);
      else pass++;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({o_data, o_length, o_start, o_overflow} !== '0) $display("FAIL reset_outputs got nonzero want 0");
      else pass++;
      @(posedge clk); #1 rst = 0;
      total++;
      if (o_byte_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_byte_ready);
      else pass++;
   endtask

   task automatic test_good_time();
      bq_t q = '{8'h47, 8'h6f, 8'h6f, 8'h64, 8'h20, 8'h74, 8'h69, 8'h6d, 8'h65};
      logic [W-1:0] want = {72'h476f6f642074696d65, 344'h0};
      send_key(q);
      total++;
      if (o_start !== 1'b1 || o_length !== 32'd9 || o_data !== want)
         $display("FAIL good_time got start=%b len=%0d data=%h want start=1 len=9 data=%h", o_start, o_length, o_data, want);
      else pass++;
      @(posedge clk); #1;
      total++;
      if (o_start !== 1'b0 || o_length !== 32'd0) $display("FAIL good_time_end got start=%b len=%0d want 0 0", o_start, o_length);
      else pass++;
   endtask

   task automatic test_stall();
      bq_t q = '{8'h47, 8'h6f, 8'h6f, 8'h64};
      int hi = 0;
      i_stall_pipe = 1'b1;
      send_key(q);
      for (int i = 0; i < 7; i++) begin
         if (o_start) hi++;
         total++;
         if (o_byte_ready !== 1'b0) $display("FAIL stall_ready cycle %0d got %b want 0", i, o_byte_ready);
         else pass++;
         if (i < 6) begin @(posedge clk); #1; end
      end
      i_stall_pipe = 1'b0;
      @(posedge clk); #1;
      total++;
      if (hi !== 7) $display("FAIL stall_hold got %0d cycles want 7", hi);
      else pass++;
      total++;
      if (o_start !== 1'b0 || o_byte_ready !== 1'b1) $display("FAIL stall_release got start=%b ready=%b want 0 1", o_start, o_byte_ready);
      else pass++;
   endtask

   task automatic test_overflow();
      bq_t q;
      for (int i = 0; i < 60; i++) q.push_back(8'(i));
      sent = 0; ovf_cnt = 0; ovf_at = -1;
      send_key(q);
      total++;
      if (o_length !== 32'd52) $display("FAIL ovf_length got %0d want 52", o_length);
      else pass++;
      wait_done();
      total++;
      if (ovf_cnt !== 1) $display("FAIL ovf_pulses got %0d want 1", ovf_cnt);
      else pass++;
      total++;
      if (ovf_at !== 53) $display("FAIL ovf_position got %0d want 53", ovf_at);
      else pass++;
   endtask

   task automatic test_back_to_back();
      bq_t a = '{8'hAA};
      bq_t b = '{8'hBB};
      starts.delete();
      send_key(a);
      send_key(b);
      wait_done();
      total++;
      if (starts.size() !== 2) $display("FAIL b2b_count got %0d want 2", starts.size());
      else begin
         pass++;
         total++;
         if (starts[1] - starts[0] !== 2) $display("FAIL b2b_spacing got %0d want 2", starts[1] - starts[0]);
         else pass++;
      end
   endtask

   task automatic test_reset_mid();
      bq_t q = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 5; i++) put(8'h50 + 8'(i), 1'b0);
      quiet();
      #2 rst = 1;
      #1;
      total++;
      if ({o_data, o_length, o_start, o_overflow} !== '0) $display("FAIL rst_mid_outputs got nonzero want 0");
      else pass++;
      @(posedge clk); #1 rst = 0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (o_start !== 1'b0 || o_byte_ready !== 1'b1) $display("FAIL rst_mid_idle got start=%b ready=%b want 0 1", o_start, o_byte_ready);
      else pass++;
      send_key(q);
      total++;
      if (o_data !== {24'h112233, 392'h0} || o_length !== 32'd3) $display("FAIL rst_mid_key got len=%0d data=%h", o_length, o_data);
      else pass++;
      wait_done();
   endtask

   task automatic test_last_no_valid();
      i_byte_valid = 1'b0; i_byte_last = 1'b1; i_byte = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      quiet();
      total++;
      if (o_start !== 1'b0 || o_byte_ready !== 1'b1 || o_data !== '0) $display("FAIL last_no_valid got start=%b ready=%b", o_start, o_byte_ready);
      else pass++;
   endtask

   initial begin
      test_reset();
      test_good_time();
      test_stall();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_last_no_valid();
      repeat (3) @(posedge clk);
      total++;
      if (sb.size() !== 0) $display("FAIL sb_leftover got %0d want 0", sb.size());
      else pass++;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
